// File: rtl/hazard_sched_pkg.sv
// rtl/hazard_sched_pkg.sv - shared encodings for the hazard scheduler
package hazard_sched_pkg;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

endpackage

// File: rtl/hazard_mc_fsm.sv
// rtl/hazard_mc_fsm.sv - handshake FSM holding a multi-cycle op in E
module hazard_mc_fsm
  import hazard_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mc_opE,
  input  logic mc_ready,
  input  logic flush_req,
  output logic mc_start,
  output logic mc_abort,
  output logic mc_busy,
  output logic mc_stall
);

  mc_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= MC_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MC_IDLE: if (mc_opE && !flush_req) state_d = MC_BUSY;
      MC_BUSY: begin
        if (flush_req)     state_d = MC_IDLE;
        else if (mc_ready) state_d = MC_DONE;
      end
      MC_DONE: state_d = MC_IDLE;
      default: state_d = MC_IDLE;
    endcase
  end

  // Reset masks every pulse so a reset in BUSY never reaches the unit as an abort.
  always_comb begin
    mc_start = 1'b0;
    mc_abort = 1'b0;
    mc_busy  = 1'b0;
    mc_stall = 1'b0;
    if (!rst) begin
      case (state_q)
        MC_IDLE: begin
          mc_start = mc_opE && !flush_req;
          mc_stall = mc_opE && !flush_req;
        end
        MC_BUSY: begin
          mc_busy  = 1'b1;
          mc_stall = 1'b1;
          mc_abort = flush_req;
        end
        MC_DONE: mc_busy = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - forwarding selects, load-use/branch/multi-cycle stalls and flushes
module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rsD,
  input  logic [AW-1:0] rtD,
  input  logic [AW-1:0] rsE,
  input  logic [AW-1:0] rtE,
  input  logic [AW-1:0] writeregE,
  input  logic [AW-1:0] writeregM,
  input  logic [AW-1:0] writeregW,
  input  logic          regwriteE,
  input  logic          regwriteM,
  input  logic          regwriteW,
  input  logic          memtoregE,
  input  logic          memtoregM,
  input  logic          branchD,
  input  logic          mc_opE,
  input  logic          mc_ready,
  input  logic          flush_req,
  output logic          mc_start,
  output logic          mc_abort,
  output logic          mc_busy,
  output logic          stallF,
  output logic          stallD,
  output logic          stallE,
  output logic          flushD,
  output logic          flushE,
  output logic [1:0]    forwardaE,
  output logic [1:0]    forwardbE,
  output logic          forwardaD,
  output logic          forwardbD
);

  localparam logic [1:0] LU_EXT = 2'(LOAD_LAT - 1);

  logic [1:0] lu_cnt_q, lu_cnt_d;
  logic       lu_hit, lu_stall, branchstall, mc_stall;

  hazard_mc_fsm u_mc_fsm (
    .clk       (clk),
    .rst       (rst),
    .mc_opE    (mc_opE),
    .mc_ready  (mc_ready),
    .flush_req (flush_req),
    .mc_start  (mc_start),
    .mc_abort  (mc_abort),
    .mc_busy   (mc_busy),
    .mc_stall  (mc_stall)
  );

  always_comb begin
    forwardaE = FWD_RF;
    if (rsE != '0 && rsE == writeregM && regwriteM)      forwardaE = FWD_M;
    else if (rsE != '0 && rsE == writeregW && regwriteW) forwardaE = FWD_W;
    forwardbE = FWD_RF;
    if (rtE != '0 && rtE == writeregM && regwriteM)      forwardbE = FWD_M;
    else if (rtE != '0 && rtE == writeregW && regwriteW) forwardbE = FWD_W;
    forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
    forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;
  end

  assign lu_hit = memtoregE && (rtE != '0) && (rtE == rsD || rtE == rtD);

  // While the counter runs, a fresh hit is the same load still in flight, so it is ignored.
  always_comb begin
    lu_stall = lu_hit || (lu_cnt_q != 2'd0);
    lu_cnt_d = lu_cnt_q;
    if (flush_req)              lu_cnt_d = 2'd0;
    else if (lu_cnt_q != 2'd0)  lu_cnt_d = lu_cnt_q - 2'd1;
    else if (lu_hit)            lu_cnt_d = LU_EXT;
  end

  always_ff @(posedge clk) begin
    if (rst) lu_cnt_q <= 2'd0;
    else     lu_cnt_q <= lu_cnt_d;
  end

  assign branchstall = branchD && (
      (regwriteE && writeregE != '0 && (writeregE == rsD || writeregE == rtD)) ||
      (memtoregM && writeregM != '0 && (writeregM == rsD || writeregM == rtD)));

  // A flush overrides every stall; a held E stage must not be bubbled.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (!rst) begin
      if (flush_req) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else begin
        stallE = mc_stall;
        stallF = lu_stall || branchstall || mc_stall;
        stallD = lu_stall || branchstall || mc_stall;
        flushE = lu_stall && !mc_stall;
      end
    end
  end

endmodule
